// File: rtl/clock_reset_pkg.sv
// Purpose: shared sequencer state encoding and default constants for the clock/reset controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_reset_pkg;

    // Defaults: 50 MHz core, one 1 MHz-capable channel pair, three staged resets.
    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_DIV_W       = 8;
    localparam int DEF_NUM_RST     = 3;
    localparam int DEF_RST_CYCLES  = 255;
    localparam int DEF_RST_STAGGER = 16;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// Purpose: one programmable clock divider channel (enable strobe + ~50% divided clock).
// Latency: strobe combinational from registered count; divided clock toggles one cycle after strobe.
// Backpressure: none; free-running, no flow control.
//
// Ports:
//   clk_i, reset_i   - system clock, synchronous active-high reset
//   div_i            - divisor captured into the pending register on div_load_i
//   div_load_i       - one-cycle load strobe
//   clk_en_o         - high for the cycle the counter sits at its terminal count
//   clk_div_o        - registered divided clock, period 2*(D+1)
module clock_divider_channel #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_load_i,
    output logic             clk_en_o,
    output logic             clk_div_o
);

    logic [DIV_W-1:0] active_q;
    logic [DIV_W-1:0] pending_q;
    logic [DIV_W-1:0] cnt_q;
    logic             pend_vld_q;
    logic             clk_div_q;
    logic             enabled;
    logic             terminal;

    assign enabled   = (active_q != '0);
    assign terminal  = enabled && (cnt_q == active_q);
    assign clk_en_o  = terminal;
    assign clk_div_o = clk_div_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            active_q   <= '0;
            pending_q  <= '0;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            clk_div_q  <= 1'b0;
        end else begin
            if (terminal) begin
                // Period boundary: the only point a running channel may change divisor.
                cnt_q <= '0;
                if (pend_vld_q) begin
                    active_q   <= pending_q;
                    pend_vld_q <= 1'b0;
                    // Switching to disabled parks the clock low right at the boundary.
                    clk_div_q  <= (pending_q == '0) ? 1'b0 : ~clk_div_q;
                end else begin
                    clk_div_q <= ~clk_div_q;
                end
            end else if (enabled) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                // Disabled: nothing to protect, adopt a pending divisor immediately.
                cnt_q     <= '0;
                clk_div_q <= 1'b0;
                if (pend_vld_q) begin
                    active_q   <= pending_q;
                    pend_vld_q <= 1'b0;
                end
            end

            // A new load always wins over the clear from an adoption on the same edge.
            if (div_load_i) begin
                pending_q  <= div_i;
                pend_vld_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_reset_controller.sv
// Purpose: NUM_CH programmable clock dividers plus a staged reset sequencer (HOLD -> STAGGER -> RUN).
// Latency: reset_o bit b releases RST_CYCLES + b*RST_STAGGER cycles after reset/soft-reset release.
// Backpressure: none; free-running, no flow control.
//
// Ports:
//   clk_i, reset_i          - system clock, synchronous active-high reset (beats everything)
//   div_i, div_load_i       - packed per-channel divisors and their load strobe
//   soft_reset_i            - level request to restart the reset sequence (dividers unaffected)
//   clk_en_o, clk_div_o     - per-channel strobe and divided clock
//   reset_o, locked         - staged domain resets (bit 0 first) and all-released flag
module clock_reset_controller
    import clock_reset_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int NUM_RST     = DEF_NUM_RST,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int RST_STAGGER = DEF_RST_STAGGER
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic                    div_load_i,
    input  logic                    soft_reset_i,
    output logic [NUM_CH-1:0]       clk_en_o,
    output logic [NUM_CH-1:0]       clk_div_o,
    output logic [NUM_RST-1:0]      reset_o,
    output logic                    locked
);

    localparam int CNT_W = $clog2(max_int(RST_CYCLES, RST_STAGGER) + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(RST_STAGGER - 1);

    // ---------------- dividers ----------------
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        clock_divider_channel #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .div_i      (div_i[n*DIV_W +: DIV_W]),
            .div_load_i (div_load_i),
            .clk_en_o   (clk_en_o[n]),
            .clk_div_o  (clk_div_o[n])
        );
    end

    // ---------------- reset sequencer ----------------
    seq_state_e         state_q;
    logic [CNT_W-1:0]   seq_cnt_q;
    logic [NUM_RST-1:0] reset_q;
    logic               locked_q;
    logic [NUM_RST-1:0] rst_shift;

    // Bits release in ascending order, so releasing the next one is a left shift
    // of the still-asserted mask; an all-zero result means the last bit just went.
    always_comb begin
        rst_shift = reset_q << 1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || soft_reset_i) begin
            state_q   <= ST_HOLD;
            seq_cnt_q <= '0;
            reset_q   <= '1;
            locked_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD, ST_STAGGER: begin
                    if (seq_cnt_q == ((state_q == ST_HOLD) ? HOLD_LAST : STAG_LAST)) begin
                        seq_cnt_q <= '0;
                        reset_q   <= rst_shift;
                        if (rst_shift == '0) begin
                            state_q  <= ST_RUN;
                            locked_q <= 1'b1;
                        end else begin
                            state_q <= ST_STAGGER;
                        end
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    locked_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_HOLD;
                end
            endcase
        end
    end

    assign reset_o = reset_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_clock_reset_controller.sv
module tb_clock_reset_controller;

    localparam int NUM_CH  = 2;
    localparam int DIV_W   = 8;
    localparam int NUM_RST = 3;
    localparam int RC      = 255;
    localparam int RS      = 16;
    localparam int LOCK_T  = RC + (NUM_RST - 1) * RS;

    logic                    clk_i = 1'b0;
    logic                    reset_i;
    logic [NUM_CH*DIV_W-1:0] div_i;
    logic                    div_load_i;
    logic                    soft_reset_i;
    logic [NUM_CH-1:0]       clk_en_o;
    logic [NUM_CH-1:0]       clk_div_o;
    logic [NUM_RST-1:0]      reset_o;
    logic                    locked;

    always #5 clk_i = ~clk_i;

    clock_reset_controller #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .NUM_RST     (NUM_RST),
        .RST_CYCLES  (RC),
        .RST_STAGGER (RS)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .div_i        (div_i),
        .div_load_i   (div_load_i),
        .soft_reset_i (soft_reset_i),
        .clk_en_o     (clk_en_o),
        .clk_div_o    (clk_div_o),
        .reset_o      (reset_o),
        .locked       (locked)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: divider as "position within a period of D+1 cycles",
    // reset sequencer as "cycles elapsed since the hold phase began".
    int m_act [NUM_CH];
    int m_pend[NUM_CH];
    bit m_pv  [NUM_CH];
    int m_pos [NUM_CH];
    bit m_clk [NUM_CH];
    int hold_t;

    int   en_q[$];
    int   tog_q[$];
    logic prev_div0;

    int rel, lock_cyc, bit0_cyc, ld, s0, s1, idx, r1, first_en, soft_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        int d;
        if (reset_i) begin
            for (int n = 0; n < NUM_CH; n++) begin
                m_act[n] = 0; m_pend[n] = 0; m_pv[n] = 0; m_pos[n] = 0; m_clk[n] = 0;
            end
            hold_t = 0;
            return;
        end
        for (int n = 0; n < NUM_CH; n++) begin
            d = int'(div_i[n*DIV_W +: DIV_W]);
            if (m_act[n] == 0) begin
                m_pos[n] = 0;
                m_clk[n] = 0;
                if (m_pv[n]) begin m_act[n] = m_pend[n]; m_pv[n] = 0; end
            end else if (m_pos[n] == m_act[n]) begin
                m_pos[n] = 0;
                m_clk[n] = !m_clk[n];
                if (m_pv[n]) begin
                    if (m_pend[n] == 0) m_clk[n] = 0;
                    m_act[n] = m_pend[n];
                    m_pv[n]  = 0;
                end
            end else begin
                m_pos[n]++;
            end
            if (div_load_i) begin m_pend[n] = d; m_pv[n] = 1; end
        end
        if (soft_reset_i) hold_t = 0;
        else if (hold_t < 100000) hold_t++;
    endtask

    task automatic tick();
        logic [NUM_CH-1:0]  e_en, e_div;
        logic [NUM_RST-1:0] e_rst;
        for (int n = 0; n < NUM_CH; n++) begin
            e_en[n]  = (m_act[n] != 0) && (m_pos[n] == m_act[n]);
            e_div[n] = m_clk[n];
        end
        for (int b = 0; b < NUM_RST; b++) e_rst[b] = (hold_t < RC + b * RS);
        check("clk_en_o",  32'(clk_en_o),  32'(e_en));
        check("clk_div_o", 32'(clk_div_o), 32'(e_div));
        check("reset_o",   32'(reset_o),   32'(e_rst));
        check("locked",    32'(locked),    32'(hold_t >= LOCK_T));
        if (clk_en_o[0] === 1'b1) en_q.push_back(cyc);
        if (clk_div_o[0] !== prev_div0) tog_q.push_back(cyc);
        prev_div0 = clk_div_o[0];
        model_step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input int d1, input int d0);
        div_i      = {DIV_W'(d1), DIV_W'(d0)};
        div_load_i = 1'b1;
        tick();
        div_load_i = 1'b0;
    endtask

    initial begin
        reset_i      = 1'b1;
        div_load_i   = 1'b0;
        soft_reset_i = 1'b0;
        div_i        = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            m_act[n] = 0; m_pend[n] = 0; m_pv[n] = 0; m_pos[n] = 0; m_clk[n] = 0;
        end
        hold_t    = 0;
        prev_div0 = 1'b0;
        @(posedge clk_i);
        #1;

        // Reset state and staged release.
        run(3);
        reset_i  = 1'b0;
        rel      = cyc;
        lock_cyc = -1;
        bit0_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            if (reset_o[0] === 1'b0 && bit0_cyc < 0) bit0_cyc = cyc;
            if (locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
            tick();
        end
        check("bit0_release_time", 32'(bit0_cyc - rel), 32'(RC));
        check("lock_time",         32'(lock_cyc - rel), 32'(LOCK_T));

        // Divide by 25 on channel 0.
        r1 = $urandom_range(1, 9);
        load(r1, 24);
        en_q.delete();
        tog_q.delete();
        run(130);
        check("div24_strobes", 32'(en_q.size() >= 4), 32'd1);
        for (int i = 1; i < en_q.size(); i++) check("div24_spacing", 32'(en_q[i] - en_q[i-1]), 32'd25);
        for (int i = 1; i < tog_q.size(); i++) check("div24_half_period", 32'(tog_q[i] - tog_q[i-1]), 32'd25);
        if (en_q.size() > 0 && tog_q.size() > 0)
            check("div24_toggle_after_strobe", 32'(tog_q[0] - en_q[0]), 32'd1);

        // Change to D=3 mid-period: current 25-cycle period must complete.
        run(7);
        ld = cyc;
        load(r1, 3);
        run(60);
        s0 = -1; s1 = -1; idx = -1;
        for (int i = 0; i < en_q.size(); i++) begin
            if (en_q[i] <= ld) s0 = en_q[i];
            else if (s1 < 0) begin s1 = en_q[i]; idx = i; end
        end
        check("glitch_free_period", 32'(s1 - s0), 32'd25);
        check("glitch_new_strobes", 32'(idx >= 0 && en_q.size() - idx >= 4), 32'd1);
        for (int k = 0; k < 3; k++)
            if (idx >= 0 && idx + k + 1 < en_q.size())
                check("new_div3_spacing", 32'(en_q[idx+k+1] - en_q[idx+k]), 32'd4);

        // Disable, then re-enable with D=1.
        load(r1, 0);
        run(10);
        en_q.delete();
        run(20);
        check("disabled_no_strobe", 32'(en_q.size()), 32'd0);
        check("disabled_clk_low",   32'(clk_div_o[0]), 32'd0);
        ld = cyc;
        load(r1, 1);
        run(20);
        first_en = (en_q.size() > 0) ? en_q[0] : ld + 1000;
        check("enable_start", 32'(first_en - ld <= 3), 32'd1);
        for (int i = 1; i < en_q.size(); i++) check("div1_spacing", 32'(en_q[i] - en_q[i-1]), 32'd2);

        // Soft reset in RUN: sequence restarts, divided clock keeps running.
        check("pre_soft_locked", 32'(locked), 32'd1);
        tog_q.delete();
        soft_reset_i = 1'b1;
        tick();
        check("soft_reset_o", 32'(reset_o), 32'h7);
        check("soft_locked",  32'(locked),  32'd0);
        run(4);
        soft_reset_i = 1'b0;
        rel      = cyc;
        lock_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            if (locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
            tick();
        end
        check("soft_lock_time", 32'(lock_cyc - rel), 32'(LOCK_T));
        check("soft_div_toggles", 32'(tog_q.size() > 100), 32'd1);
        for (int i = 1; i < tog_q.size(); i++) check("soft_div_continuity", 32'(tog_q[i] - tog_q[i-1]), 32'd2);

        // Hard reset in the middle of STAGGER.
        soft_reset_i = 1'b1;
        tick();
        soft_reset_i = 1'b0;
        run(265);
        check("mid_stagger_reset_o", 32'(reset_o), 32'h6);
        reset_i = 1'b1;
        tick();
        check("midreset_reset_o", 32'(reset_o),   32'h7);
        check("midreset_locked",  32'(locked),    32'd0);
        check("midreset_clk_en",  32'(clk_en_o),  32'd0);
        check("midreset_clk_div", 32'(clk_div_o), 32'd0);
        run(2);
        reset_i = 1'b0;
        run(5);

        // Randomized loads and soft-reset pulses against the model.
        soft_left = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                div_i      = {DIV_W'($urandom_range(0, 6)), DIV_W'($urandom_range(0, 6))};
                div_load_i = 1'b1;
            end else begin
                div_load_i = 1'b0;
            end
            if (soft_left == 0 && $urandom_range(0, 199) == 0) soft_left = $urandom_range(1, 6);
            soft_reset_i = (soft_left > 0);
            if (soft_left > 0) soft_left--;
            tick();
        end
        div_load_i   = 1'b0;
        soft_reset_i = 1'b0;
        run(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
